// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Loader state encoding and word/address constants shared with the
//            PC / instruction-memory address logic.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int INST_ADDR_SHIFT = 2;

endpackage
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : inst_loader_if
// Purpose   : Byte stream, instruction-memory write port and status of the
//             boot loader. slave = loader side, master = host side.
// Revision  : 1.0
// ============================================================================
interface inst_loader_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Assembles 4 bytes MSB-first into a 32-bit word with a one-cycle
//            registered word-valid pulse; synchronous clear.
// Revision : 1.0
// ============================================================================
module byte_packer
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_idx,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_cnt   <= 2'd0;
                r_shift <= 24'd0;
            end else if (i_byte_valid) begin
                if (r_cnt == c_last_byte) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end else begin
                    r_shift <= {r_shift[15:0], i_byte};
                end
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign o_byte_idx   = r_cnt;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Purpose  : Boot loader filling instruction memory from a byte stream and
//            holding the core in reset until the load completes.
//            Option: INST_LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Revision : 1.0
// ============================================================================
module inst_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    inst_loader_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH) + 1;
    localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

    loader_state_t    r_state;
    logic             r_in_ready;
    logic             r_cpu_hold;
    logic             r_done;
    logic             r_error;
    logic             r_data_end;
    logic [7:0]       r_len_hi;
    logic [CNT_W-1:0] r_len;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_imem_addr;

    logic             w_xfer;
    logic             w_start_ok;
    logic             w_data_byte;
    logic             w_last_word;
    logic [CNT_W-1:0] w_len;
    logic [1:0]       w_byte_idx;
    logic [31:0]      w_word;
    logic             w_word_valid;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_start_ok  = bus.start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_data_byte = w_xfer && (r_state == DATA);
    assign w_len       = CNT_W'({r_len_hi, bus.in_data});
    assign w_last_word = (CNT_W'(r_word_idx) + CNT_W'(1)) == r_len;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_chk;

    assign w_sum_chk = r_sum + bus.in_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= 8'd0;
        end else if (w_start_ok) begin
            r_sum <= 8'd0;
        end else if (w_xfer && (r_state != CHECK)) begin
            r_sum <= w_sum_chk;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_data_end  <= 1'b0;
            r_len_hi    <= 8'd0;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_imem_addr <= 32'd0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (w_start_ok) begin
                        r_state    <= LEN_HI;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_data_end <= 1'b0;
                        r_len      <= '0;
                        r_word_idx <= '0;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= bus.in_data;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            r_state    <= CHECK;
`else
                            r_state    <= DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end else if (w_len > CNT_W'(DEPTH)) begin
                            r_state    <= ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Wait out the final strobe so the last write lands before the core is released.
                    if (r_data_end) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else if (w_xfer && (w_byte_idx == c_last_byte)) begin
                        r_imem_addr <= 32'(r_word_idx) << INST_ADDR_SHIFT;
                        r_word_idx  <= r_word_idx + IDX_W'(1);
                        if (w_last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            r_state    <= CHECK;
`else
                            r_data_end <= 1'b1;
                            r_in_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (w_sum_chk == 8'h00) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_byte_valid (w_data_byte),
        .i_byte       (bus.in_data),
        .o_byte_idx   (w_byte_idx),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = w_word_valid;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = w_word;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Purpose  : Directed self-checking bench for inst_loader (DEPTH=256, CNT_W=16).
// Revision : 1.0
// ============================================================================
module tb_inst_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  stim[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    inst_loader_if bus ();

    inst_loader #(.DEPTH(256), .CNT_W(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // A strobe is high for exactly one full cycle, so it is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("xfer_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gap);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (gap && i != stim.size() - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_imem_we",  32'(bus.imem_we),  32'd0);
        check("rst_addr",     bus.imem_addr,     32'd0);
        check("rst_wdata",    bus.imem_wdata,    32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_error",    32'(bus.error),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load N=2 back-to-back
        pulse_start();
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
`ifdef INST_LOADER_CHECKSUM_EN
        stim.push_back(8'h1C);
        send_stim(1'b0);
        check("n2_done", 32'(bus.done), 32'd1);
`else
        send_stim(1'b0);
        check("n2_strobe",     32'(bus.imem_we),  32'd1);
        check("n2_strobe_hold", 32'(bus.cpu_hold), 32'd1);
        check("n2_strobe_done", 32'(bus.done),     32'd0);
        @(negedge clk);
        check("n2_done",     32'(bus.done),     32'd1);
        check("n2_hold_low", 32'(bus.cpu_hold), 32'd0);
        check("n2_we_low",   32'(bus.imem_we),  32'd0);
`endif
        check("n2_error",  32'(bus.error),     32'd0);
        check("n2_nwr",    32'(wr_addr_q.size()), 32'd2);
        check("n2_addr0",  wr_addr_q[0], 32'h0000_0000);
        check("n2_data0",  wr_data_q[0], 32'h2008_0005);
        check("n2_addr1",  wr_addr_q[1], 32'h0000_0004);
        check("n2_data1",  wr_data_q[1], 32'hAC09_0000);

        // Same stream with gaps, restarted from DONE
        clear_writes();
        pulse_start();
        check("rs_hold", 32'(bus.cpu_hold), 32'd1);
        check("rs_done", 32'(bus.done),     32'd0);
        send_stim(1'b1);
        repeat (2) @(negedge clk);
        check("gap_done",  32'(bus.done),        32'd1);
        check("gap_nwr",   32'(wr_addr_q.size()), 32'd2);
        check("gap_addr0", wr_addr_q[0], 32'h0000_0000);
        check("gap_data0", wr_data_q[0], 32'h2008_0005);
        check("gap_addr1", wr_addr_q[1], 32'h0000_0004);
        check("gap_data1", wr_data_q[1], 32'hAC09_0000);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("done_in_ready", 32'(bus.in_ready),   32'd0);
        check("done_nwr",      32'(wr_addr_q.size()), 32'd2);
        check("done_stays",    32'(bus.done),       32'd1);
        bus.in_valid = 1'b0;

        // N=0
        clear_writes();
        pulse_start();
        stim = '{8'h00, 8'h00};
`ifdef INST_LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        send_stim(1'b0);
        check("n0_done",  32'(bus.done),        32'd1);
        check("n0_hold",  32'(bus.cpu_hold),    32'd0);
        repeat (2) @(negedge clk);
        check("n0_nwr",   32'(wr_addr_q.size()), 32'd0);

        // N=DEPTH+1
        pulse_start();
        stim = '{8'h01, 8'h01};
        send_stim(1'b0);
        check("ovf_error",    32'(bus.error),    32'd1);
        check("ovf_done",     32'(bus.done),     32'd0);
        check("ovf_hold",     32'(bus.cpu_hold), 32'd1);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("ovf_nwr", 32'(wr_addr_q.size()), 32'd0);

        // Reset after 6 payload bytes, then fresh N=1 load
        pulse_start();
        check("err_clear", 32'(bus.error), 32'd0);
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09};
        send_stim(1'b0);
        check("part_nwr", 32'(wr_addr_q.size()), 32'd1);
        clear_writes();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_we",       32'(bus.imem_we),  32'd0);
        check("mid_rst_hold",     32'(bus.cpu_hold), 32'd1);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        stim = '{8'h00, 8'h01, 8'h8C, 8'h0A, 8'h00, 8'h04};
`ifdef INST_LOADER_CHECKSUM_EN
        stim.push_back(8'h65);
`endif
        send_stim(1'b0);
        repeat (2) @(negedge clk);
        check("n1_done",  32'(bus.done),        32'd1);
        check("n1_nwr",   32'(wr_addr_q.size()), 32'd1);
        check("n1_addr0", wr_addr_q[0], 32'h0000_0000);
        check("n1_data0", wr_data_q[0], 32'h8C0A_0004);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum good / bad
        clear_writes();
        pulse_start();
        stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFE};
        send_stim(1'b0);
        check("ck_ok_done",  32'(bus.done),  32'd1);
        check("ck_ok_error", 32'(bus.error), 32'd0);
        clear_writes();
        pulse_start();
        stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
        send_stim(1'b0);
        repeat (2) @(negedge clk);
        check("ck_bad_error", 32'(bus.error),       32'd1);
        check("ck_bad_done",  32'(bus.done),        32'd0);
        check("ck_bad_hold",  32'(bus.cpu_hold),    32'd1);
        check("ck_bad_nwr",   32'(wr_addr_q.size()), 32'd1);
        check("ck_bad_data0", wr_data_q[0], 32'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
